sta_job_arbiter: RTL and testbench

- Shares a single STA timing core between two requesters, one job at a time.
- Grants the core round-robin and streams the granted requester's delay/edge beats into the core.
- Waits for the core's worst-delay/path response and routes it back, tagged, to the owning requester.
- Guards against a hung core with a response timeout; sits between the job-issuing logic and the STA core.

---
 rtl/sta_job_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_sta_job_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sta_job_arbiter.sv
// Two-requester arbiter for a shared STA timing core: grants the core round-robin,
// streams the owner's beats in, and routes the core's response (or a timeout) back.
`timescale 1ns/1ps

module sta_job_arbiter #(
    parameter int NUM_BEAT = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] beat_valid,
    input  logic [7:0] delay_in,
    input  logic [7:0] src_in,
    input  logic [7:0] dst_in,
    output logic [1:0] gnt,
    output logic       sta_in_valid,
    output logic [3:0] sta_delay,
    output logic [3:0] sta_source,
    output logic [3:0] sta_destination,
    input  logic       sta_out_valid,
    input  logic [7:0] sta_worst_delay,
    input  logic [3:0] sta_path,
    output logic [1:0] res_valid,
    output logic       res_first,
    output logic [7:0] res_worst_delay,
    output logic [3:0] res_path,
    output logic [1:0] res_timeout,
    output logic [1:0] proto_err
);

    localparam int BW = (NUM_BEAT > 1) ? $clog2(NUM_BEAT) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEAT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            owner_q, owner_d;
    logic            prefer_q, prefer_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            sta_in_valid_q, sta_in_valid_d;
    logic [3:0]      sta_delay_q, sta_delay_d;
    logic [3:0]      sta_source_q, sta_source_d;
    logic [3:0]      sta_destination_q, sta_destination_d;
    logic [1:0]      res_valid_q, res_valid_d;
    logic            res_first_q, res_first_d;
    logic [7:0]      res_worst_delay_q, res_worst_delay_d;
    logic [3:0]      res_path_q, res_path_d;
    logic [1:0]      res_timeout_q, res_timeout_d;
    logic [1:0]      proto_err_q, proto_err_d;

    // Owner's lane; the other requester's inputs never reach the core.
    logic       lane_valid;
    logic [3:0] lane_delay;
    logic [3:0] lane_src;
    logic [3:0] lane_dst;
    logic       arb_win;
    logic       delay_beat;

    always_comb begin
        lane_valid = owner_q ? beat_valid[1]  : beat_valid[0];
        lane_delay = owner_q ? delay_in[7:4]  : delay_in[3:0];
        lane_src   = owner_q ? src_in[7:4]    : src_in[3:0];
        lane_dst   = owner_q ? dst_in[7:4]    : dst_in[3:0];
        // Both requesting: take the preferred one; otherwise whichever is asking.
        arb_win    = (req == 2'b11) ? prefer_q : req[1];
        delay_beat = 32'(beat_cnt_q) < 32'd16;
    end

    // NOTE: every next-state variable gets its hold/zero default before the case so no path can infer a latch.
    always_comb begin
        state_d           = state_q;
        gnt_d             = gnt_q;
        owner_d           = owner_q;
        prefer_d          = prefer_q;
        beat_cnt_d        = beat_cnt_q;
        tmo_cnt_d         = tmo_cnt_q;
        proto_err_d       = proto_err_q;
        sta_in_valid_d    = 1'b0;
        sta_delay_d       = 4'd0;
        sta_source_d      = 4'd0;
        sta_destination_d = 4'd0;
        res_valid_d       = 2'b00;
        res_first_d       = 1'b0;
        res_worst_delay_d = 8'd0;
        res_path_d        = 4'd0;
        res_timeout_d     = 2'b00;

        case (state_q)
            S_IDLE: begin
                // Stale core output arriving here is dropped on purpose.
                if (|req) begin
                    owner_d    = arb_win;
                    gnt_d      = arb_win ? 2'b10 : 2'b01;
                    beat_cnt_d = '0;
                    state_d    = S_LOAD;
                end
            end

            S_LOAD: begin
                sta_in_valid_d = 1'b1;
                if (lane_valid) begin
                    sta_source_d      = lane_src;
                    sta_destination_d = lane_dst;
                    sta_delay_d       = delay_beat ? lane_delay : 4'd0;
                end else begin
                    proto_err_d[owner_q] = 1'b1;
                end
                if (beat_cnt_q == LAST_BEAT) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT;
                end else begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
            end

            S_WAIT: begin
                // A response on the timeout cycle still wins.
                if (sta_out_valid) begin
                    res_valid_d       = gnt_q;
                    res_first_d       = 1'b1;
                    res_worst_delay_d = sta_worst_delay;
                    res_path_d        = sta_path;
                    state_d           = S_DRAIN;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    res_timeout_d = gnt_q;
                    gnt_d         = 2'b00;
                    prefer_d      = ~owner_q;
                    state_d       = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end

            S_DRAIN: begin
                if (sta_out_valid) begin
                    res_valid_d = gnt_q;
                    res_path_d  = sta_path;
                end else begin
                    gnt_d    = 2'b00;
                    prefer_d = ~owner_q;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            gnt_q             <= 2'b00;
            owner_q           <= 1'b0;
            prefer_q          <= 1'b0;
            beat_cnt_q        <= '0;
            tmo_cnt_q         <= '0;
            sta_in_valid_q    <= 1'b0;
            sta_delay_q       <= 4'd0;
            sta_source_q      <= 4'd0;
            sta_destination_q <= 4'd0;
            res_valid_q       <= 2'b00;
            res_first_q       <= 1'b0;
            res_worst_delay_q <= 8'd0;
            res_path_q        <= 4'd0;
            res_timeout_q     <= 2'b00;
            proto_err_q       <= 2'b00;
        end else begin
            state_q           <= state_d;
            gnt_q             <= gnt_d;
            owner_q           <= owner_d;
            prefer_q          <= prefer_d;
            beat_cnt_q        <= beat_cnt_d;
            tmo_cnt_q         <= tmo_cnt_d;
            sta_in_valid_q    <= sta_in_valid_d;
            sta_delay_q       <= sta_delay_d;
            sta_source_q      <= sta_source_d;
            sta_destination_q <= sta_destination_d;
            res_valid_q       <= res_valid_d;
            res_first_q       <= res_first_d;
            res_worst_delay_q <= res_worst_delay_d;
            res_path_q        <= res_path_d;
            res_timeout_q     <= res_timeout_d;
            proto_err_q       <= proto_err_d;
        end
    end

    assign gnt             = gnt_q;
    assign sta_in_valid    = sta_in_valid_q;
    assign sta_delay       = sta_delay_q;
    assign sta_source      = sta_source_q;
    assign sta_destination = sta_destination_q;
    assign res_valid       = res_valid_q;
    assign res_first       = res_first_q;
    assign res_worst_delay = res_worst_delay_q;
    assign res_path        = res_path_q;
    assign res_timeout     = res_timeout_q;
    assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_sta_job_arbiter.sv
// Scoreboard bench for sta_job_arbiter: directed jobs push expected core beats,
// results and timeouts into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_sta_job_arbiter;

    localparam int NUM_BEAT = 32;
    localparam int TIMEOUT  = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] beat_valid = '0;
    logic [7:0] delay_in = '0;
    logic [7:0] src_in = '0;
    logic [7:0] dst_in = '0;
    logic       sta_out_valid = 1'b0;
    logic [7:0] sta_worst_delay = '0;
    logic [3:0] sta_path = '0;
    logic [1:0] gnt;
    logic       sta_in_valid;
    logic [3:0] sta_delay, sta_source, sta_destination;
    logic [1:0] res_valid;
    logic       res_first;
    logic [7:0] res_worst_delay;
    logic [3:0] res_path;
    logic [1:0] res_timeout;
    logic [1:0] proto_err;

    sta_job_arbiter #(.NUM_BEAT(NUM_BEAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .beat_valid(beat_valid),
        .delay_in(delay_in), .src_in(src_in), .dst_in(dst_in), .gnt(gnt),
        .sta_in_valid(sta_in_valid), .sta_delay(sta_delay), .sta_source(sta_source),
        .sta_destination(sta_destination), .sta_out_valid(sta_out_valid),
        .sta_worst_delay(sta_worst_delay), .sta_path(sta_path), .res_valid(res_valid),
        .res_first(res_first), .res_worst_delay(res_worst_delay), .res_path(res_path),
        .res_timeout(res_timeout), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {logic [3:0] d; logic [3:0] s; logic [3:0] t;} beat_t;
    typedef struct packed {logic [1:0] v; logic f; logic [7:0] wd; logic [3:0] p;} res_t;
    typedef struct packed {logic [1:0] v; logic [31:0] c;} tmo_t;

    beat_t sta_q[$];
    res_t  res_q[$];
    tmo_t  tmo_q[$];

    int total = 0;
    int bad   = 0;
    int wait_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: output with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    int sta_run = 0;
    always @(negedge clk) begin
        beat_t eb;
        res_t  er;
        tmo_t  et;
        if (rst) begin
            sta_run = 0;
        end else begin
            if (sta_in_valid) begin
                sta_run++;
                if (sta_q.size() == 0) unexpected("sta_beat");
                else begin
                    eb = sta_q.pop_front();
                    check("sta_delay", 32'(sta_delay), 32'(eb.d));
                    check("sta_source", 32'(sta_source), 32'(eb.s));
                    check("sta_destination", 32'(sta_destination), 32'(eb.t));
                end
            end else if (sta_run > 0) begin
                check("sta_run_len", sta_run, NUM_BEAT);
                sta_run = 0;
            end
            if (res_valid != 2'b00) begin
                if (res_q.size() == 0) unexpected("res_beat");
                else begin
                    er = res_q.pop_front();
                    check("res_valid", 32'(res_valid), 32'(er.v));
                    check("res_first", 32'(res_first), 32'(er.f));
                    check("res_worst_delay", 32'(res_worst_delay), 32'(er.wd));
                    check("res_path", 32'(res_path), 32'(er.p));
                end
            end else begin
                check("res_idle_zero", 32'({res_first, res_worst_delay, res_path}), 32'd0);
            end
            if (res_timeout != 2'b00) begin
                if (tmo_q.size() == 0) unexpected("res_timeout");
                else begin
                    et = tmo_q.pop_front();
                    check("res_timeout_val", 32'(res_timeout), 32'(et.v));
                    check("res_timeout_cycle", cyc, et.c);
                end
            end
        end
    end

    task automatic clear_inputs();
        beat_valid = 2'b00;
        delay_in   = '0;
        src_in     = '0;
        dst_in     = '0;
    endtask

    task automatic wait_grant(input logic [1:0] exp);
        int i;
        i = 0;
        @(negedge clk);
        while (gnt == 2'b00 && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("grant", 32'(gnt), 32'(exp));
        check("sta_idle_at_grant", 32'(sta_in_valid), 32'd0);
    endtask

    // Drives the owner lane with seed-derived beats and garbage on the other lane.
    task automatic load_job(input int w, input int s, input int bad_beat, input int abort_at);
        logic [3:0] d, sr, ds;
        logic       bv;
        beat_t      eb;
        for (int b = 0; b < NUM_BEAT; b++) begin
            if (b == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_sta_in_valid", 32'(sta_in_valid), 32'd0);
                check("rst_gnt", 32'(gnt), 32'd0);
                check("rst_res", 32'({res_valid, res_first, res_worst_delay, res_path, res_timeout}), 32'd0);
                check("rst_proto_err", 32'(proto_err), 32'd0);
                clear_inputs();
                return;
            end
            d  = 4'(b + 1 + s);
            sr = 4'(b * 3 + s);
            ds = 4'(b * 5 + 1 + s);
            bv = (b != bad_beat);
            delay_in = {~d, ~d};
            src_in   = {~sr, ~sr};
            dst_in   = {~ds, ~ds};
            delay_in[w*4 +: 4] = d;
            src_in[w*4 +: 4]   = sr;
            dst_in[w*4 +: 4]   = ds;
            beat_valid    = 2'b00;
            beat_valid[w] = bv;
            if (bv) eb = '{d: (b < 16) ? d : 4'd0, s: sr, t: ds};
            else    eb = '{d: 4'd0, s: 4'd0, t: 4'd0};
            sta_q.push_back(eb);
            @(negedge clk);
            if (b == 0) check("sta_latency", 32'(sta_in_valid), 32'd1);
        end
        clear_inputs();
        wait_cyc = cyc;
    endtask

    task automatic respond(input int w, input logic [7:0] wd, input logic [15:0] paths, input int gap);
        logic [1:0] oh;
        oh = (w == 1) ? 2'b10 : 2'b01;
        repeat (gap) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sta_out_valid   = 1'b1;
            sta_worst_delay = wd + 8'(k);
            sta_path        = paths[k*4 +: 4];
            res_q.push_back('{v: oh, f: (k == 0), wd: (k == 0) ? wd : 8'd0, p: paths[k*4 +: 4]});
            @(negedge clk);
        end
        sta_out_valid   = 1'b0;
        sta_worst_delay = '0;
        sta_path        = '0;
        @(negedge clk);
        check("gnt_release", 32'(gnt), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_sta", 32'({sta_in_valid, sta_delay, sta_source, sta_destination}), 32'd0);
        check("reset_res", 32'({res_valid, res_first, res_worst_delay, res_path, res_timeout}), 32'd0);
        check("reset_proto_err", 32'(proto_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Both requesting from reset: req0, req1, req0.
        req = 2'b11;
        wait_grant(2'b01);
        load_job(0, 0, -1, -1);
        respond(0, 8'd42, 16'hF730, 3);

        wait_grant(2'b10);
        load_job(1, 5, -1, -1);
        respond(1, 8'h99, 16'h8642, 0);

        // Third job drops beat_valid on beat 5; response lands on the timeout cycle.
        wait_grant(2'b01);
        req = 2'b00;
        load_job(0, 9, 5, -1);
        respond(0, 8'h17, 16'h3211, TIMEOUT - 1);
        check("proto_err_set", 32'(proto_err), 32'd1);

        // Silent core: timeout exactly TIMEOUT cycles after WAIT entry.
        req = 2'b10;
        wait_grant(2'b10);
        req = 2'b00;
        load_job(1, 2, -1, -1);
        tmo_q.push_back('{v: 2'b10, c: 32'(wait_cyc + TIMEOUT)});
        for (int i = 0; i < TIMEOUT + 20 && gnt != 2'b00; i++) @(negedge clk);
        check("gnt_after_timeout", 32'(gnt), 32'd0);

        // Late core output in IDLE must be dropped.
        sta_out_valid   = 1'b1;
        sta_worst_delay = 8'h77;
        sta_path        = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_out_dropped", 32'(res_valid), 32'd0);
        end
        sta_out_valid   = 1'b0;
        sta_worst_delay = '0;
        sta_path        = '0;

        req = 2'b01;
        wait_grant(2'b01);
        req = 2'b00;
        load_job(0, 1, -1, -1);
        respond(0, 8'h05, 16'h6789, 1);
        check("proto_err_sticky", 32'(proto_err), 32'd1);

        // Asynchronous reset in the middle of LOAD.
        req = 2'b10;
        wait_grant(2'b10);
        req = 2'b00;
        load_job(1, 3, -1, 10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        req = 2'b10;
        wait_grant(2'b10);
        req = 2'b00;
        load_job(1, 4, -1, -1);
        respond(1, 8'hC3, 16'h0F0F, 2);
        check("proto_err_after_rst", 32'(proto_err), 32'd0);

        repeat (3) @(negedge clk);
        check("sta_q_empty", sta_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);
        check("tmo_q_empty", tmo_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
